// File: rtl/adder_tree_pipelined_pkg.sv
// Shared sizing helpers for the pipelined popcount tree.
// Parent blocks can import this to align side-band data with the tree latency.
package adder_tree_pkg;

  function automatic int tree_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

  function automatic int sum_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

  function automatic int tree_latency(input int n, input int stride);
    int lat;
    lat = (tree_levels(n) + stride - 1) / stride;
    return (lat < 1) ? 1 : lat;
  endfunction

  // Each level halves the lane count, rounding up so odd lanes pair with zero.
  function automatic int lanes_at(input int n, input int level);
    int c;
    c = n;
    for (int i = 0; i < level; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/adder_tree_pipelined_if.sv
// Sample-in / count-out bundle of the pipelined popcount tree.
interface adder_tree_pipelined_if
  import adder_tree_pkg::*;
#(
  parameter int N_INPUTS = 4
) ();

  localparam int SUM_W = sum_width(N_INPUTS);

  logic                en;
  logic                in_valid;
  logic [N_INPUTS-1:0] inputs;
  logic                out_valid;
  logic [SUM_W-1:0]    sum;

  modport master (
    output en, in_valid, inputs,
    input  out_valid, sum
  );

  modport slave (
    input  en, in_valid, inputs,
    output out_valid, sum
  );

endinterface

// File: rtl/adder_tree_pipelined_level.sv
// One tree level: adds adjacent lane pairs, with an optional enable-gated output register.
module adder_tree_level #(
  parameter int N_LANES    = 4,
  parameter int IN_W       = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             i_en,
  input  logic [N_LANES*IN_W-1:0]          i_lanes,
  output logic [((N_LANES+1)/2)*(IN_W+1)-1:0] o_lanes
);

  localparam int OUT_LANES = (N_LANES + 1) / 2;
  localparam int OUT_W     = IN_W + 1;

  logic [OUT_LANES*OUT_W-1:0] w_sum;

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_pair
    logic [OUT_W-1:0] w_a;
    logic [OUT_W-1:0] w_b;

    assign w_a = {1'b0, i_lanes[2*j*IN_W +: IN_W]};
    if (2*j + 1 < N_LANES) begin : g_partner
      assign w_b = {1'b0, i_lanes[(2*j+1)*IN_W +: IN_W]};
    end else begin : g_pad
      assign w_b = '0;
    end
    assign w_sum[j*OUT_W +: OUT_W] = w_a + w_b;
  end

  if (REGISTERED) begin : g_reg
    logic [OUT_LANES*OUT_W-1:0] r_out;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_out <= '0;
      end else if (i_en) begin
        r_out <= w_sum;
      end
    end

    assign o_lanes = r_out;
  end else begin : g_comb
    // Clock and control only matter for registered levels.
    logic w_unused;
    assign w_unused = ^{CLK, RST, i_en};
    assign o_lanes  = w_sum;
  end

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined popcount of N_INPUTS bitstream lanes, registered every REG_STRIDE levels,
// with a valid shift register matched to the tree latency.
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int REG_STRIDE = 1
) (
  input logic                    CLK,
  input logic                    RST,
  adder_tree_pipelined_if.slave  bus
);

  localparam int L     = tree_levels(N_INPUTS);
  localparam int SUM_W = sum_width(N_INPUTS);
  localparam int LAT   = tree_latency(N_INPUTS, REG_STRIDE);

  logic [LAT-1:0] r_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
    end else if (bus.en) begin
      r_valid[0] <= bus.in_valid;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign bus.out_valid = r_valid[LAT-1];

  if (L == 0) begin : g_single
    logic [SUM_W-1:0] r_sum;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_sum <= '0;
      end else if (bus.en) begin
        r_sum <= SUM_W'(bus.inputs);
      end
    end

    assign bus.sum = r_sum;
  end else begin : g_tree
    for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int  IN_LANES  = lanes_at(N_INPUTS, k - 1);
      localparam int  OUT_LANES = lanes_at(N_INPUTS, k);
      localparam bit  IS_REG    = ((k % REG_STRIDE) == 0) || (k == L);

      logic [IN_LANES*k-1:0]      w_in;
      logic [OUT_LANES*(k+1)-1:0] w_out;

      if (k == 1) begin : g_first
        assign w_in = bus.inputs;
      end else begin : g_chain
        assign w_in = g_lvl[k-1].w_out;
      end

      adder_tree_level #(
        .N_LANES    (IN_LANES),
        .IN_W       (k),
        .REGISTERED (IS_REG)
      ) u_level (
        .CLK     (CLK),
        .RST     (RST),
        .i_en    (bus.en),
        .i_lanes (w_in),
        .o_lanes (w_out)
      );

      // The root is wider than needed; the count always fits in SUM_W bits.
      if (k == L) begin : g_root
        assign bus.sum = SUM_W'(w_out);
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Drives five tree configurations with shared stimulus and checks each against
// a popcount history indexed by enabled clock edges.
module tb_adder_tree_pipelined;
  import adder_tree_pkg::*;

  localparam int NUM_DUT = 5;
  localparam int NS[NUM_DUT]  = '{1, 4, 5, 8, 16};
  localparam int STR[NUM_DUT] = '{1, 1, 2, 1, 1};
  localparam int HIST = 4096;

  logic        CLK;
  logic        tbRst;
  logic        tbEn;
  logic        tbInValid;
  logic [15:0] tbInputs;

  logic [NUM_DUT-1:0] obsValid;
  logic [31:0]        obsSum [NUM_DUT];

  int assertCount;
  int failCount;

  bit histValid [HIST];
  int histData  [HIST];
  int edgeCount;
  int resetMark;

  adder_tree_pipelined_if #(.N_INPUTS(1))  bus1  ();
  adder_tree_pipelined_if #(.N_INPUTS(4))  bus4  ();
  adder_tree_pipelined_if #(.N_INPUTS(5))  bus5  ();
  adder_tree_pipelined_if #(.N_INPUTS(8))  bus8  ();
  adder_tree_pipelined_if #(.N_INPUTS(16)) bus16 ();

  adder_tree_pipelined #(.N_INPUTS(1),  .REG_STRIDE(1)) dut1  (.CLK(CLK), .RST(tbRst), .bus(bus1.slave));
  adder_tree_pipelined #(.N_INPUTS(4),  .REG_STRIDE(1)) dut4  (.CLK(CLK), .RST(tbRst), .bus(bus4.slave));
  adder_tree_pipelined #(.N_INPUTS(5),  .REG_STRIDE(2)) dut5  (.CLK(CLK), .RST(tbRst), .bus(bus5.slave));
  adder_tree_pipelined #(.N_INPUTS(8),  .REG_STRIDE(1)) dut8  (.CLK(CLK), .RST(tbRst), .bus(bus8.slave));
  adder_tree_pipelined #(.N_INPUTS(16), .REG_STRIDE(1)) dut16 (.CLK(CLK), .RST(tbRst), .bus(bus16.slave));

  assign bus1.en  = tbEn;  assign bus1.in_valid  = tbInValid;  assign bus1.inputs  = tbInputs[0:0];
  assign bus4.en  = tbEn;  assign bus4.in_valid  = tbInValid;  assign bus4.inputs  = tbInputs[3:0];
  assign bus5.en  = tbEn;  assign bus5.in_valid  = tbInValid;  assign bus5.inputs  = tbInputs[4:0];
  assign bus8.en  = tbEn;  assign bus8.in_valid  = tbInValid;  assign bus8.inputs  = tbInputs[7:0];
  assign bus16.en = tbEn;  assign bus16.in_valid = tbInValid;  assign bus16.inputs = tbInputs[15:0];

  assign obsValid = {bus16.out_valid, bus8.out_valid, bus5.out_valid, bus4.out_valid, bus1.out_valid};
  assign obsSum[0] = 32'(bus1.sum);
  assign obsSum[1] = 32'(bus4.sum);
  assign obsSum[2] = 32'(bus5.sum);
  assign obsSum[3] = 32'(bus8.sum);
  assign obsSum[4] = 32'(bus16.sum);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // A sample taken at enabled edge e is due once LAT more enabled edges have passed,
  // unless a reset has happened since it was taken.
  task automatic applyStimulus(input logic rst, input logic en, input logic inValid, input logic [15:0] data);
    int idx;
    int lat;
    int expSum;
    bit expValid;
    tbRst     = rst;
    tbEn      = en;
    tbInValid = inValid;
    tbInputs  = data;
    @(posedge CLK);
    if (rst) begin
      resetMark = edgeCount;
    end else if (en) begin
      histValid[edgeCount] = inValid;
      histData[edgeCount]  = int'(data);
      edgeCount++;
    end
    #1;
    for (int i = 0; i < NUM_DUT; i++) begin
      lat = tree_latency(NS[i], STR[i]);
      idx = edgeCount - lat;
      expValid = (idx >= resetMark) ? histValid[idx] : 1'b0;
      checkOutput($sformatf("valid_n%0d", NS[i]), 32'(obsValid[i]), 32'(expValid));
      if (expValid) begin
        expSum = $countones(histData[idx] & ((1 << NS[i]) - 1));
        checkOutput($sformatf("sum_n%0d", NS[i]), obsSum[i], expSum);
      end
      if (rst) begin
        checkOutput($sformatf("rstsum_n%0d", NS[i]), obsSum[i], 0);
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    edgeCount   = 0;
    resetMark   = 0;
    tbRst = 1'b1; tbEn = 1'b0; tbInValid = 1'b0; tbInputs = '0;

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Single all-ones pulse: N=4 reports 4 exactly two edges later, then drops valid.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h000F);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    checkOutput("pulse4_valid", 32'(obsValid[1]), 1);
    checkOutput("pulse4_sum", obsSum[1], 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("pulse4_drop", 32'(obsValid[1]), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Back-to-back samples on N=5 / stride 2.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0015);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h001F);
    checkOutput("b2b5_first", obsSum[2], 3);
    checkOutput("b2b5_valid1", 32'(obsValid[2]), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("b2b5_second", obsSum[2], 5);
    checkOutput("b2b5_valid2", 32'(obsValid[2]), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Stall two cycles while 8'hFF is in flight through N=8.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00FF);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003);
    checkOutput("stall8_early", 32'(obsValid[3]), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stall8_valid", 32'(obsValid[3]), 1);
    checkOutput("stall8_sum", obsSum[3], 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stall8_nodup", 32'(obsValid[3]), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Nonzero data with in_valid low between valid samples.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h8001);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hAAAA);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Fill every pipeline, reset once, and make sure nothing stale comes out.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'(32'h9E37 * (i + 1)));
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF);
    checkOutput("rst_valid_any", 32'(obsValid), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) < 6), 16'($urandom));
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipelined.md
# adder_tree_pipelined

Parametrised, pipelined population-count adder tree. It sums `N_INPUTS` 1-bit stochastic bitstream lanes into one binary count per cycle. Register stages are placed at a configurable stride, and a valid flag travels with the data. A clock enable stalls the whole pipeline. It replaces fixed-size combinational trees wherever a wide bitstream vector is reduced to a count, for example in dot products and stochastic-to-binary conversion.

## Interface
Parameters:
- `N_INPUTS`, 4: number of 1-bit input lanes, ≥1, any value (not limited to powers of two).
- `REG_STRIDE`, 1: insert a pipeline register after every `REG_STRIDE` tree levels, ≥1.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `en`  in  1  clock enable; 0 holds every pipeline register, including valid bits.
- `in_valid`  in  1  `inputs` carries a sample this cycle.
- `inputs`  in  `N_INPUTS`  bitstream lanes, one bit each.
- `out_valid`  out  1  `sum` holds a completed count.
- `sum`  out  `SUM_W = clog2(N_INPUTS+1)`  number of ones in the matching input sample.

## Operation
- Tree depth: `L = clog2(N_INPUTS)`.
  - The input vector is zero-padded to `2^L` lanes.
  - Level k (1..L) adds adjacent pairs from level k-1; its partial sums are k+1 bits wide.
  - The final level is truncated to `SUM_W`, which is lossless.
- Register placement:
  - A register follows level k when `k % REG_STRIDE == 0` or `k == L`.
  - For `N_INPUTS == 1` (L = 0), a single output register is used.
  - The output is always registered.
- Latency: `LAT = max(1, ceil(L / REG_STRIDE))` cycles from `in_valid` sampled to `out_valid`.
- Valid pipeline:
  - A `LAT`-deep shift register carries `in_valid` alongside the data.
  - Data registers load unconditionally when `en=1`, whatever the valid bit.
  - `sum` is meaningful only when `out_valid=1`.
- Stall (`en=0`):
  - All data and valid registers hold.
  - Inputs presented during a stall are ignored.
  - Throughput is 1 sample/cycle whenever `en=1`.
- Reset (`RST=1` at an edge):
  - All data registers, valid bits, `sum` and `out_valid` become 0.
  - In-flight samples are discarded, never emitted.
  - `RST` has priority over `en`.
- No overflow is possible: the maximum count is `N_INPUTS`, which fits in `SUM_W`.

## Timing
- Reset values: `sum = 0`, `out_valid = 0`, all internal stages 0.
- A sample accepted at edge t (with `en=1`, `in_valid=1`) appears with `out_valid=1` after `LAT` enabled edges.
  - With no stalls, it is visible in the cycle after edge t+LAT-1.
  - Each `en=0` cycle adds one cycle to the latency.
- Back-to-back valid samples emerge back-to-back, in order, with no bubbles.
- On the cycle `RST` deasserts, `out_valid` stays 0 for at least `LAT` enabled edges.
- Asserting `RST` and `en` together: reset wins.

## Structure
- Shared package `adder_tree_pkg`:
  - functions `tree_levels(n)`, `sum_width(n)`, `tree_latency(n, stride)`;
  - used by this block and by any parent that must align side-band data to `LAT`.
- Sub-module `adder_tree_level`, one tree level. Parameters: input lane count, input width, `REGISTERED`. Behaviour:
  - performs the pairwise adds, with odd-lane zero padding;
  - when registered, it has an optional `en`/`RST`-controlled output register.
- The top level:
  - instantiates L levels via generate, computing each level's `REGISTERED` from `REG_STRIDE`;
  - holds the valid shift register.

## Test plan
- `N_INPUTS=4`, `REG_STRIDE=1`:
  - stimulus: `inputs=4'b1111` with `in_valid=1` for one cycle;
  - required response: `out_valid=1`, `sum=3'd4` exactly 2 cycles later, then `out_valid=0`.
- `N_INPUTS=5`, `REG_STRIDE=2`:
  - stimulus: `5'b10101` then `5'b11111` back-to-back;
  - required response: `sum` 3 then 5 on consecutive cycles after `LAT=2`.
- Stall, `N_INPUTS=8`, `REG_STRIDE=1` (`LAT=3`):
  - stimulus: send `8'hFF`, then drop `en` for 2 cycles mid-flight;
  - required response: `sum=4'd8` with `out_valid` after 5 cycles, with no duplicate or lost sample.
- Reset mid-operation:
  - stimulus: fill the pipeline with valid samples, then assert `RST` for 1 cycle;
  - required response: `sum=0`, `out_valid=0` next cycle, and no stale sample emitted afterwards.
- `N_INPUTS=1` and `N_INPUTS=16`:
  - stimulus: drive random streams of 1000 samples with random `en`/`in_valid`;
  - required response: every output matches a scoreboard popcount in order; `LAT` is 1 and 4 respectively.
- `in_valid=0` samples:
  - stimulus: present nonzero `inputs` with `in_valid=0`;
  - required response: `out_valid` stays 0 for those slots, and surrounding valid samples are unaffected.
